// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: bundles the scan-out pixel address/data, CPU bus and
// framebuffer RAM signals of vga_fb_arbiter into one port.
// Ports (slave = arbiter side):
//   in : h_addr, v_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb, ram_rdata
//   out: vga_data, cpu_gnt, cpu_rvalid, cpu_rdata, wfifo_cnt,
//        ram_en, ram_we, ram_addr, ram_wdata
// The master modport is the mirror image, for whatever drives the arbiter.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W  = 19,
    parameter int WFIFO_D = 4
);
    localparam int CNT_W = $clog2(WFIFO_D) + 1;

    // Scan-out side
    logic [9:0]        h_addr;
    logic [9:0]        v_addr;
    logic [31:0]       vga_data;

    // CPU bus side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic [CNT_W-1:0]  wfifo_cnt;

    // Framebuffer RAM side
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  h_addr, v_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  ram_rdata,
        output vga_data,
        output cpu_gnt, cpu_rvalid, cpu_rdata, wfifo_cnt,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output h_addr, v_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output ram_rdata,
        input  vga_data,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, wfifo_cnt,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// fb_sync_fifo: generic synchronous FIFO with registered occupancy count.
// Latency: a pushed entry is visible at head_dat_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller uses cnt_o.
// Ports: clk, rst_n (async, active-low), push_vld_i/push_dat_i, pop_i,
//        head_dat_o (oldest entry), cnt_o (entries held).
module fb_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_vld_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_vld_i & (cnt_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i & (cnt_q != '0);

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: only entries counted by cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;
endmodule

// vga_fb_arbiter: shares one single-port sync framebuffer RAM between scan-out and CPU.
// Latency: scan-out pixel 1 cycle after its fetch; CPU read data 1 cycle after gnt.
// Backpressure: CPU writes posted into a WFIFO_D FIFO (gnt=0 when full); reads wait for blanking.
// Ports: pclk, reset (async, active-low), bus (vga_fb_arbiter_if.slave):
//   h_addr/v_addr -> vga_data        next pixel position in, pixel word out
//   cpu_req/we/addr/wdata/wstrb      CPU request held until cpu_gnt
//   cpu_gnt/rvalid/rdata, wfifo_cnt  CPU accept, read return, posted writes pending
//   ram_en/we/addr/wdata, ram_rdata  framebuffer RAM port
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int WFIFO_D  = 4
) (
    input  logic            pclk,
    input  logic            reset,
    vga_fb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(WFIFO_D) + 1;

    // One posted CPU write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
    } wr_ent_t;

    localparam int ENT_W = $bits(wr_ent_t);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_RESP = 1'b1
    } rd_state_e;

    rd_state_e         state_q, state_d;
    logic              vga_slot_dly_q, vga_slot_dly_d;

    logic              vga_slot;
    logic [ADDR_W-1:0] vga_ram_addr;
    wr_ent_t           push_ent;
    wr_ent_t           head_ent;
    logic [ENT_W-1:0]  head_raw;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_has_room;
    logic              wr_accept;
    logic              fifo_pop;
    logic              rd_issue;

    // ------------------------------------------------------------------
    // Scan-out slot detection. Both coordinates are unsigned 10-bit, so the
    // wrapped values vga_ctrl produces around the line/frame start (e.g. 1023)
    // fall outside the active window. Gated by reset so the RAM stays idle
    // while reset is held, whatever vga_ctrl is presenting.
    // ------------------------------------------------------------------
    assign vga_slot = reset
                    & (bus.h_addr < 10'(H_ACTIVE))
                    & (bus.v_addr < 10'(V_ACTIVE));

    // Linear pixel address, one word per pixel, truncated to the RAM width.
    assign vga_ram_addr = ADDR_W'(32'(bus.v_addr) * 32'(H_ACTIVE) + 32'(bus.h_addr));

    // ------------------------------------------------------------------
    // Posted-write FIFO. Accept looks only at the registered count, so a
    // full FIFO refuses a write even in a cycle where it is also draining;
    // this keeps cpu_gnt off the vga_slot -> pop path.
    // ------------------------------------------------------------------
    assign push_ent.addr  = bus.cpu_addr;
    assign push_ent.wdata = bus.cpu_wdata;
    assign push_ent.wstrb = bus.cpu_wstrb;

    assign fifo_has_room = (fifo_cnt < CNT_W'(WFIFO_D));
    assign fifo_empty    = (fifo_cnt == '0);
    assign wr_accept     = reset & bus.cpu_req & bus.cpu_we & fifo_has_room;

    // Drain only in cycles the scan-out does not need the RAM.
    assign fifo_pop = reset & ~vga_slot & ~fifo_empty;

    fb_sync_fifo #(
        .W     (ENT_W),
        .DEPTH (WFIFO_D)
    ) u_wfifo (
        .clk        (pclk),
        .rst_n      (reset),
        .push_vld_i (wr_accept),
        .push_dat_i (push_ent),
        .pop_i      (fifo_pop),
        .head_dat_o (head_raw),
        .cnt_o      (fifo_cnt)
    );

    assign head_ent      = wr_ent_t'(head_raw);
    assign bus.wfifo_cnt = fifo_cnt;

    // ------------------------------------------------------------------
    // Read issue. Waiting for an empty FIFO makes every read observe all
    // earlier posted writes; only one read may be outstanding at a time.
    // ------------------------------------------------------------------
    assign rd_issue = reset & ~vga_slot & fifo_empty & (state_q == ST_IDLE)
                    & bus.cpu_req & ~bus.cpu_we;

    assign bus.cpu_gnt = wr_accept | rd_issue;

    // ------------------------------------------------------------------
    // RAM port owner, highest priority first: scan-out, FIFO drain, CPU read.
    // ------------------------------------------------------------------
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 4'b0000;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (vga_slot) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = vga_ram_addr;
        end else if (fifo_pop) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = head_ent.wstrb;
            bus.ram_addr  = head_ent.addr;
            bus.ram_wdata = head_ent.wdata;
        end else if (rd_issue) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.cpu_addr;
        end
    end

    // ------------------------------------------------------------------
    // Scan-out return path: the sync RAM answers one cycle after the fetch,
    // so remember whether last cycle was a scan-out fetch.
    // ------------------------------------------------------------------
    assign vga_slot_dly_d = vga_slot;
    assign bus.vga_data   = vga_slot_dly_q ? bus.ram_rdata : 32'h0;

    // ------------------------------------------------------------------
    // Read-response FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            vga_slot_dly_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vga_slot_dly_q <= vga_slot_dly_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.cpu_rvalid = 1'b0;
        bus.cpu_rdata  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (rd_issue) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                // RAM data for the read issued last cycle is on ram_rdata now.
                bus.cpu_rvalid = 1'b1;
                bus.cpu_rdata  = bus.ram_rdata;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
